expr_string_gen: RTL and testbench

- Generator for the ASCII digit/operator expression strings checked by the codebase's expression recognizer.
- Collects an expression as a sequence of tokens, one pushed per cycle. Each token is an operand digit plus the operator that follows it.
- Serialises the expression as one ASCII byte per accepted transfer: digit, op, digit, ..., digit.
- Output stream feeds the recognizer's byte input, or a bench checker, through a valid/ready handshake.

---
 rtl/expr_string_gen.sv | 77 +++++++
 tb/tb_expr_string_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/expr_string_gen.sv
// expr_string_gen: collects digit/operator tokens and streams them out as an
// ASCII expression "d op d op ... d" over a valid/ready byte interface.
module expr_string_gen #(
  parameter int MAX_OPS = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       push_valid,
  output logic       push_ready,
  input  logic [3:0] push_digit,
  input  logic       push_op,
  input  logic       push_last,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       err
);
  localparam int CW = $clog2(MAX_OPS + 1);
  localparam int IW = MAX_OPS > 1 ? $clog2(MAX_OPS) : 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] MAX = CW'(MAX_OPS);
  typedef enum logic [1:0] {LOAD, SEND_DIG, SEND_OP} state_t;
  state_t state, state_n;
  logic [CW-1:0] count, idx, nxt;
  logic [3:0] dig [2**IW];
  logic op [2**IW];
  logic [3:0] dval;
  logic acc, fin;
  assign push_ready = state == LOAD;
  assign out_valid = state != LOAD;
  assign acc = push_valid && push_ready;
  assign fin = push_last || count + ONE == MAX;
  assign dval = push_digit > 4'd9 ? 4'd0 : push_digit;
  assign nxt = idx + ONE;
  always_comb begin
    state_n = state;
    state_n = state == LOAD ? (acc && fin ? SEND_DIG : LOAD) :
              state == SEND_DIG ? (out_ready ? (out_last ? LOAD : SEND_OP) : SEND_DIG) :
              (out_ready ? SEND_DIG : SEND_OP);
  end
  always_ff @(posedge clk) state <= clr ? LOAD : state_n;
  always_ff @(posedge clk) begin
    if (clr) begin
      count    <= '0;
      idx      <= '0;
      out      <= 8'h00;
      out_last <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (acc) begin
        dig[count[IW-1:0]] <= dval;
        op[count[IW-1:0]]  <= push_op;
        count <= count + ONE;
        err   <= err | (push_digit > 4'd9);
        // the first digit may be the token arriving this very cycle
        if (fin) begin
          idx      <= '0;
          out      <= 8'h30 + {4'h0, count == '0 ? dval : dig[0]};
          out_last <= count == '0;
        end
      end
      if (state == SEND_DIG && out_ready) begin
        if (out_last) count <= '0;
        else begin
          out      <= op[idx[IW-1:0]] ? 8'h2A : 8'h2B;
          out_last <= 1'b0;
        end
      end
      if (state == SEND_OP && out_ready) begin
        idx      <= nxt;
        out      <= 8'h30 + {4'h0, dig[nxt[IW-1:0]]};
        out_last <= nxt == count - ONE;
      end
    end
  end
endmodule

// File: tb/tb_expr_string_gen.sv
// tb_expr_string_gen: directed scenario bench for expr_string_gen.
module tb_expr_string_gen;
  logic clk = 1'b0, clr = 1'b1, push_valid = 1'b0, push_op = 1'b0, push_last = 1'b0, out_ready = 1'b1;
  logic [3:0] push_digit = 4'd0;
  logic push_ready, out_valid, out_last, err;
  logic [7:0] out;
  int compared = 0, mismatched = 0;
  expr_string_gen #(.MAX_OPS(8)) dut (
    .clk(clk), .clr(clr), .push_valid(push_valid), .push_ready(push_ready),
    .push_digit(push_digit), .push_op(push_op), .push_last(push_last),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .err(err)
  );
  always #5 clk = ~clk;
  task automatic push(input logic [3:0] d, input logic o, input logic l);
    push_valid = 1'b1; push_digit = d; push_op = o; push_last = l;
    @(negedge clk);
    push_valid = 1'b0; push_last = 1'b0;
  endtask
  task automatic test_reset;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    compared++;
    if ({out, out_valid, out_last, push_ready, err} !== {8'h00, 4'b0010}) begin
      mismatched++;
      $display("FAIL reset out=%h valid=%b last=%b pready=%b err=%b required 00 0 0 1 0", out, out_valid, out_last, push_ready, err);
    end
  endtask
  task automatic test_single;
    out_ready = 1'b1;
    push(4'd7, 1'b0, 1'b1);
    compared++;
    if ({out, out_valid, out_last, push_ready} !== {8'h37, 3'b110}) begin
      mismatched++;
      $display("FAIL single_byte out=%h valid=%b last=%b pready=%b required 37 1 1 0", out, out_valid, out_last, push_ready);
    end
    @(negedge clk);
    compared++;
    if ({out_valid, push_ready, out} !== {2'b01, 8'h37}) begin
      mismatched++;
      $display("FAIL single_after valid=%b pready=%b out=%h required 0 1 37", out_valid, push_ready, out);
    end
  endtask
  task automatic test_three;
    logic [7:0] exp [5] = '{8'h33, 8'h2B, 8'h34, 8'h2A, 8'h35};
    out_ready = 1'b1;
    push(4'd3, 1'b0, 1'b0);
    push(4'd4, 1'b1, 1'b0);
    push(4'd5, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      compared++;
      if ({out_valid, out, out_last} !== {1'b1, exp[i], i == 4}) begin
        mismatched++;
        $display("FAIL three_byte%0d valid=%b out=%h last=%b required 1 %h %b", i, out_valid, out, out_last, exp[i], i == 4);
      end
      @(negedge clk);
    end
    compared++;
    if ({out_valid, push_ready, err} !== 3'b010) begin
      mismatched++;
      $display("FAIL three_end valid=%b pready=%b err=%b required 0 1 0", out_valid, push_ready, err);
    end
  endtask
  task automatic test_stall;
    logic [7:0] exp [8] = '{8'h33, 8'h2B, 8'h2B, 8'h2B, 8'h2B, 8'h34, 8'h2A, 8'h35};
    out_ready = 1'b1;
    push(4'd3, 1'b0, 1'b0);
    push(4'd4, 1'b1, 1'b0);
    push(4'd5, 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      out_ready = !(c >= 1 && c <= 3);
      compared++;
      if ({out_valid, out, out_last} !== {1'b1, exp[c], c == 7}) begin
        mismatched++;
        $display("FAIL stall_cyc%0d valid=%b out=%h last=%b required 1 %h %b", c, out_valid, out, out_last, exp[c], c == 7);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    compared++;
    if ({out_valid, push_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL stall_end valid=%b pready=%b required 0 1", out_valid, push_ready);
    end
  endtask
  task automatic test_overflow;
    logic [7:0] e;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(4'(i), 1'b1, 1'b0);
    compared++;
    if (push_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL overflow_pready got=%b required 0", push_ready);
    end
    for (int i = 0; i < 15; i++) begin
      e = (i % 2 == 0) ? 8'(8'h31 + i / 2) : 8'h2A;
      compared++;
      if ({out_valid, out, out_last} !== {1'b1, e, i == 14}) begin
        mismatched++;
        $display("FAIL overflow_byte%0d valid=%b out=%h last=%b required 1 %h %b", i, out_valid, out, out_last, e, i == 14);
      end
      @(negedge clk);
    end
    compared++;
    if ({out_valid, push_ready, err} !== 3'b010) begin
      mismatched++;
      $display("FAIL overflow_end valid=%b pready=%b err=%b required 0 1 0", out_valid, push_ready, err);
    end
  endtask
  task automatic test_illegal;
    logic [7:0] exp [3] = '{8'h30, 8'h2B, 8'h32};
    out_ready = 1'b1;
    push(4'd12, 1'b0, 1'b0);
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL illegal_err_set got=%b required 1", err);
    end
    push(4'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      compared++;
      if ({out_valid, out, out_last} !== {1'b1, exp[i], i == 2}) begin
        mismatched++;
        $display("FAIL illegal_byte%0d valid=%b out=%h last=%b required 1 %h %b", i, out_valid, out, out_last, exp[i], i == 2);
      end
      @(negedge clk);
    end
    compared++;
    if ({out_valid, err} !== 2'b01) begin
      mismatched++;
      $display("FAIL illegal_sticky valid=%b err=%b required 0 1", out_valid, err);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL illegal_clr err=%b required 0", err);
    end
  endtask
  task automatic test_clr_mid;
    out_ready = 1'b1;
    push(4'd3, 1'b0, 1'b0);
    push(4'd4, 1'b1, 1'b0);
    push(4'd5, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    compared++;
    if ({out_valid, out} !== {1'b1, 8'h34}) begin
      mismatched++;
      $display("FAIL clrmid_pre valid=%b out=%h required 1 34", out_valid, out);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    compared++;
    if ({out_valid, out, out_last, push_ready} !== {1'b0, 8'h00, 2'b01}) begin
      mismatched++;
      $display("FAIL clrmid_post valid=%b out=%h last=%b pready=%b required 0 00 0 1", out_valid, out, out_last, push_ready);
    end
    push(4'd9, 1'b0, 1'b1);
    compared++;
    if ({out_valid, out, out_last} !== {1'b1, 8'h39, 1'b1}) begin
      mismatched++;
      $display("FAIL clrmid_new valid=%b out=%h last=%b required 1 39 1", out_valid, out, out_last);
    end
    @(negedge clk);
    compared++;
    if ({out_valid, push_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL clrmid_end valid=%b pready=%b required 0 1", out_valid, push_ready);
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_three;
    test_stall;
    test_overflow;
    test_illegal;
    test_clr_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
